// File: rtl/dijkstra_pkg.sv
// Shared types and helpers for the Dijkstra core memory bridge.
// Halfword lane mapping on the 32-bit Avalon bus lives here so bridge and bench agree.
package dijkstra_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int HALF_W     = 16;
  localparam int BE_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } state_e;

  function automatic logic [BE_W-1:0] lane_be(input logic hi);
    return hi ? 4'b1100 : 4'b0011;
  endfunction

  function automatic logic [HALF_W-1:0] lane_sel(input logic hi,
                                                 input logic [BUS_DATA_W-1:0] d);
    return hi ? d[31:16] : d[15:0];
  endfunction

endpackage

// File: rtl/dijkstra_mem_bridge_if.sv
// Avalon-MM single-beat master bus between the bridge and the memory slave.
interface dijkstra_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  import dijkstra_pkg::*;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [BE_W-1:0]   avm_byteenable;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/dijkstra_bus_watchdog.sv
// Per-transaction cycle counter; expired stays high once the limit is reached until cleared.
// A limit of 0 disables expiry entirely.
module dijkstra_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit;

  assign hit       = (TIMEOUT_CYCLES != 0) && (cnt_q >= TC);
  assign expired_o = hit;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !hit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dijkstra_mem_bridge.sv
// Core level-request/ready-pulse memory port to single-beat Avalon-MM master, one transaction in flight.
// IDLE sample | RD_REQ read issued | RD_WAIT await data | WR_REQ write issued | DONE ready pulse
module dijkstra_mem_bridge
  import dijkstra_pkg::*;
#(
  parameter int MADDR_WIDTH    = 32,
  parameter int MDATA_WIDTH    = 16,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   algorithm_clock,
  input  logic                   algorithm_reset,
  input  logic                   mem_read_enable,
  input  logic                   mem_write_enable,
  input  logic [MADDR_WIDTH-1:0] mem_addr,
  input  logic [MDATA_WIDTH-1:0] mem_write_data,
  output logic [MDATA_WIDTH-1:0] mem_read_data,
  output logic                   mem_read_ready,
  output logic                   mem_write_ready,
  output logic                   bus_error,
  dijkstra_mem_bridge_if.master  avm
);

  state_e                    state_q, state_d;
  logic                      hi_q, hi_d;
  logic [MDATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                      rd_rdy_q, rd_rdy_d;
  logic                      wr_rdy_q, wr_rdy_d;
  logic                      rd_q, rd_d;
  logic                      wr_q, wr_d;
  logic [MADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [BE_W-1:0]           be_q, be_d;
  logic [BUS_DATA_WIDTH-1:0] wd_q, wd_d;
  logic                      err_q, err_d;
  logic                      busy, expired;

  assign busy = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) || (state_q == ST_WR_REQ);

  dijkstra_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk       (algorithm_clock),
    .rst       (algorithm_reset),
    .clear_i   (state_q == ST_IDLE),
    .enable_i  (busy),
    .expired_o (expired)
  );

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    rdata_d  = rdata_q;
    rd_rdy_d = 1'b0;
    wr_rdy_d = 1'b0;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wd_d     = wd_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_read_enable || mem_write_enable) begin
          if (mem_addr[0]) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            if (mem_read_enable) begin
              rdata_d  = '0;
              rd_rdy_d = 1'b1;
            end else begin
              wr_rdy_d = 1'b1;
            end
          end else begin
            hi_d   = mem_addr[1];
            addr_d = {mem_addr[MADDR_WIDTH-1:2], 2'b00};
            be_d   = lane_be(mem_addr[1]);
            if (mem_read_enable) begin
              state_d = ST_RD_REQ;
              rd_d    = 1'b1;
            end else begin
              state_d = ST_WR_REQ;
              wr_d    = 1'b1;
              wd_d    = {mem_write_data, mem_write_data};
            end
          end
        end
      end
      ST_RD_REQ: begin
        // A completed handshake wins over a watchdog hit in the same cycle.
        if (!avm.avm_waitrequest) begin
          state_d = ST_RD_WAIT;
          rd_d    = 1'b0;
        end else if (expired) begin
          state_d  = ST_DONE;
          rd_d     = 1'b0;
          err_d    = 1'b1;
          rdata_d  = '0;
          rd_rdy_d = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (avm.avm_readdatavalid) begin
          state_d  = ST_DONE;
          rdata_d  = lane_sel(hi_q, avm.avm_readdata);
          rd_rdy_d = 1'b1;
        end else if (expired) begin
          state_d  = ST_DONE;
          err_d    = 1'b1;
          rdata_d  = '0;
          rd_rdy_d = 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (!avm.avm_waitrequest || expired) begin
          state_d  = ST_DONE;
          wr_d     = 1'b0;
          wr_rdy_d = 1'b1;
          if (avm.avm_waitrequest) err_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge algorithm_clock) begin
    if (algorithm_reset) begin
      state_q  <= ST_IDLE;
      hi_q     <= 1'b0;
      rdata_q  <= '0;
      rd_rdy_q <= 1'b0;
      wr_rdy_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      rdata_q  <= rdata_d;
      rd_rdy_q <= rd_rdy_d;
      wr_rdy_q <= wr_rdy_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
    end
  end

  assign mem_read_data      = rdata_q;
  assign mem_read_ready     = rd_rdy_q;
  assign mem_write_ready    = wr_rdy_q;
  assign bus_error          = err_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_read       = rd_q;
  assign avm.avm_write      = wr_q;
  assign avm.avm_byteenable = be_q;
  assign avm.avm_writedata  = wd_q;

endmodule

// File: tb/tb_dijkstra_mem_bridge.sv
// Scoreboard bench for dijkstra_mem_bridge: directed core requests against a scripted Avalon slave.
module tb_dijkstra_mem_bridge;
  import dijkstra_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rd_rdy, wr_rdy, berr;

  dijkstra_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) avm ();

  dijkstra_mem_bridge #(
    .MADDR_WIDTH(32), .MDATA_WIDTH(16), .BUS_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .algorithm_clock  (clk),
    .algorithm_reset  (rst),
    .mem_read_enable  (rd_en),
    .mem_write_enable (wr_en),
    .mem_addr         (addr),
    .mem_write_data   (wdata),
    .mem_read_data    (rdata),
    .mem_read_ready   (rd_rdy),
    .mem_write_ready  (wr_rdy),
    .bus_error        (berr),
    .avm              (avm)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rd_seen = 0;

  int          slave_wait = 0;
  logic [31:0] slave_rdata = '0;
  bit          slave_send_rdv = 1'b1;
  bit          stray_rdv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (avm.avm_read) rd_seen <= rd_seen + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scripted slave: slave_wait waitrequest cycles per access, readdatavalid one cycle after accept.
  initial begin
    int  wait_left = 0;
    bit  rdv_pending = 1'b0;
    avm.avm_waitrequest   = 1'b0;
    avm.avm_readdata      = '0;
    avm.avm_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      avm.avm_readdata      = slave_rdata;
      avm.avm_readdatavalid = (rdv_pending && slave_send_rdv) || stray_rdv;
      rdv_pending = 1'b0;
      if (avm.avm_read || avm.avm_write) begin
        if (wait_left > 0) begin
          avm.avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          avm.avm_waitrequest = 1'b0;
          if (avm.avm_read) rdv_pending = 1'b1;
        end
      end else begin
        avm.avm_waitrequest = 1'b0;
        wait_left = slave_wait;
      end
    end
  end

  // Monitor: every ready pulse must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_rdy || wr_rdy) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ready rd=%0b wr=%0b cycle=%0d", rd_rdy, wr_rdy, cyc);
        end else begin
          e = q.pop_front();
          if (rd_rdy !== e.is_rd || wr_rdy !== !e.is_rd || cyc != e.cyc ||
              (e.is_rd && rdata !== e.data)) begin
            n_err++;
            $display("FAIL ready_pulse got rd=%0b wr=%0b data=%h cycle=%0d expected rd=%0b data=%h cycle=%0d",
                     rd_rdy, wr_rdy, rdata, cyc, e.is_rd, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic push(input bit is_rd, input logic [15:0] d, input int c);
    exp_t e;
    e.is_rd = is_rd;
    e.data  = d;
    e.cyc   = c;
    q.push_back(e);
  endtask

  // Core model: hold enables until the matching ready pulse, drop them in that cycle.
  task automatic core_req(input bit r, input bit w, input logic [31:0] a, input logic [15:0] d);
    int n = 0;
    addr  = a;
    wdata = d;
    rd_en = r;
    wr_en = w;
    while ((rd_en || wr_en) && n < 100) begin
      @(negedge clk);
      n++;
      if (rd_rdy) rd_en = 1'b0;
      if (wr_rdy) wr_en = 1'b0;
    end
    if (rd_en || wr_en) begin
      n_vec++;
      n_err++;
      $display("FAIL core_req_timeout addr=%h waited=%0d cycles", a, n);
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"}, {16'h0, rdata}, 32'h0);
    chk({tag, "_avm_read"}, {31'h0, avm.avm_read}, 32'h0);
    chk({tag, "_avm_write"}, {31'h0, avm.avm_write}, 32'h0);
    chk({tag, "_avm_addr"}, avm.avm_address, 32'h0);
    chk({tag, "_avm_be"}, {28'h0, avm.avm_byteenable}, 32'h0);
    chk({tag, "_avm_wd"}, avm.avm_writedata, 32'h0);
    chk({tag, "_bus_error"}, {31'h0, berr}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit cycle=%0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int c;
    int seen0;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");
    chk("reset_ready", {30'h0, rd_rdy, wr_rdy}, 32'h0);

    // Read 0x102, upper lane, zero wait
    slave_wait = 0; slave_rdata = 32'hBEEF1234; slave_send_rdv = 1'b1;
    @(negedge clk); c = cyc;
    push(1'b1, 16'hBEEF, c + 3);
    fork
      core_req(1'b1, 1'b0, 32'h102, 16'h0);
      begin
        @(negedge clk);
        chk("rd_avm_read", {31'h0, avm.avm_read}, 32'h1);
        chk("rd_avm_addr", avm.avm_address, 32'h100);
        chk("rd_avm_be", {28'h0, avm.avm_byteenable}, 32'hC);
      end
    join

    // Write 0x200 with three waitrequest cycles, bus held stable through the stall
    slave_wait = 3;
    @(negedge clk); c = cyc;
    push(1'b0, 16'h0, c + 5);
    fork
      core_req(1'b0, 1'b1, 32'h200, 16'hA5A5);
      begin
        for (int i = 1; i <= 4; i++) begin
          @(negedge clk);
          chk($sformatf("wr_stall%0d_write", i), {31'h0, avm.avm_write}, 32'h1);
          chk($sformatf("wr_stall%0d_addr", i), avm.avm_address, 32'h200);
          chk($sformatf("wr_stall%0d_be", i), {28'h0, avm.avm_byteenable}, 32'h3);
          chk($sformatf("wr_stall%0d_wd", i), avm.avm_writedata, 32'hA5A5A5A5);
        end
      end
    join

    // Read and write together: read first, write after the idle gap
    slave_wait = 0; slave_rdata = 32'h33334444;
    @(negedge clk); c = cyc;
    push(1'b1, 16'h3333, c + 3);
    push(1'b0, 16'h0, c + 6);
    core_req(1'b1, 1'b1, 32'h106, 16'h5A5A);

    // Misaligned read: no bus cycle, data 0, sticky error
    @(negedge clk); c = cyc; seen0 = rd_seen;
    push(1'b1, 16'h0, c + 1);
    core_req(1'b1, 1'b0, 32'h101, 16'h0);
    @(negedge clk);
    chk("misalign_no_avm_read", rd_seen - seen0, 32'h0);
    chk("misalign_bus_error", {31'h0, berr}, 32'h1);
    slave_rdata = 32'hCAFEF00D;
    @(negedge clk); c = cyc;
    push(1'b1, 16'hF00D, c + 3);
    core_req(1'b1, 1'b0, 32'h100, 16'h0);
    @(negedge clk);
    chk("bus_error_sticky", {31'h0, berr}, 32'h1);

    // Reset while waiting for read data, followed by a stray readdatavalid
    slave_send_rdv = 1'b0; slave_rdata = 32'h77778888;
    @(negedge clk);
    addr = 32'h402; rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; rd_en = 1'b0;
    @(negedge clk); stray_rdv = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); stray_rdv = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midreset");
    chk("midreset_ready", {30'h0, rd_rdy, wr_rdy}, 32'h0);

    // Watchdog: read accepted, data never returns
    slave_send_rdv = 1'b0; slave_rdata = 32'h12345678;
    @(negedge clk); c = cyc;
    push(1'b1, 16'h0, c + 10);
    core_req(1'b1, 1'b0, 32'h300, 16'h0);
    chk("timeout_bus_error", {31'h0, berr}, 32'h1);
    chk("timeout_avm_read", {31'h0, avm.avm_read}, 32'h0);
    slave_send_rdv = 1'b1;

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
